mc_main_fsm: RTL and testbench
==============================

Name: mc_main_fsm

Overview:
- Parametrised next-generation main controller for the multicycle MIPS-subset datapath.
- Moore FSM drives all datapath enables and mux selects. Adds three things over the previous controller:
  - variable-latency memory handshake (MemReq/MemRdy) with a watchdog timeout;
  - extra instructions: ANDI, ORI, SLTI, BNE, JAL;
  - sticky fault reporting with a retired-instruction counter.
- Sits beside the ALU decoder; its ALUOp feeds that decoder.

Parameters:
- OPW, 6, opcode width
- ALUOPW, 3, ALUOp width
- TOW, 8, width of the memory-wait watchdog counter
- TIMEOUT, 200, max cycles to wait for MemRdy before fault (must be < 2**TOW)
- CNTW, 32, width of the retired-instruction counter

Ports:
- CLK, in, 1, clock, rising edge
- RST, in, 1, synchronous, active-high reset
- Opcode, in, OPW, IR[31:26]
- MemRdy, in, 1, memory completes the current request this cycle
- MemReq, out, 1, memory access request (fetch, load, store)
- IRWE, out, 1, instruction register write
- MWE, out, 1, data memory write (qualified with MemReq)
- PCWE, out, 1, unconditional PC write
- Branch, out, 1, PC write if ALU Zero
- BranchNE, out, 1, PC write if not Zero
- RFWE, out, 1, register file write
- ALUOp, out, ALUOPW: 000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
- ALUIn1Sel, out, 1: 0 PC, 1 RegA
- ALUIn2Sel, out, 2: 00 RegB, 01 const 4, 10 SignImm, 11 ZeroImm
- PCSel, out, 2: 00 ALUResult, 01 ALUOut, 10 jump target
- MtoRFSel, out, 2: 00 ALUOut, 01 MDR, 10 PC (link)
- RFDSel, out, 2: 00 rt, 01 rd, 10 const 31
- IDSel, out, 1: 0 PC address, 1 ALUOut address
- Fault, out, 1, sticky: illegal opcode or memory timeout
- FaultCode, out, 2: 00 none, 01 illegal opcode, 10 memory timeout
- Retired, out, CNTW, count of completed instructions

Behaviour:
- Reset: RST sampled at the CLK edge.
  - state := RESET, watchdog := 0, Retired := 0, Fault := 0, FaultCode := 00.
  - Every enable output is 0 and every select is 0; no X values in any state.
  - RST mid-instruction aborts it, with no write issued on the following cycle.
- States and transitions:
  - RESET -> FETCH.
  - FETCH: MemReq=1, IDSel=0, ALUIn1Sel=0, ALUIn2Sel=01, ALUOp=000, PCSel=00. IRWE=PCWE=MemRdy (combinational qualification). Stays in FETCH until MemRdy, then -> DECODE.
  - DECODE: ALUIn1Sel=0, ALUIn2Sel=10 (branch target precomputed into ALUOut). Dispatch:
    - LW/SW (100011/101011) -> MEMADDR
    - R-type (000000) -> EXEC
    - BEQ (000100) / BNE (000101) -> BRANCH
    - J (000010) -> JUMP
    - JAL (000011) -> JAL
    - ADDI (001000), ANDI (001100), ORI (001101), SLTI (001010) -> IEXEC
    - any other opcode -> FAULT with FaultCode=01
  - MEMADDR: ALUIn1Sel=1, ALUIn2Sel=10, ALUOp=000. LW -> MEMREAD, SW -> MEMWRITE.
  - MEMREAD: MemReq=1, IDSel=1. Waits for MemRdy, then -> MEMWB.
  - MEMWB: RFWE=1, MtoRFSel=01, RFDSel=00 -> FETCH.
  - MEMWRITE: MemReq=1, MWE=1, IDSel=1. Waits for MemRdy, then -> FETCH.
  - EXEC: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=010 -> ALUWB.
  - ALUWB: RFWE=1, MtoRFSel=00, RFDSel=01 -> FETCH.
  - BRANCH: ALUIn1Sel=1, ALUIn2Sel=00, ALUOp=001, PCSel=01. Branch=1 for BEQ, BranchNE=1 for BNE -> FETCH.
  - JUMP: PCWE=1, PCSel=10 -> FETCH.
  - JAL: PCWE=1, PCSel=10, RFWE=1, MtoRFSel=10, RFDSel=10. PC already holds PC+4 from FETCH, so this writes the link to $31 in the same cycle -> FETCH.
  - IEXEC: ALUIn1Sel=1. ALUIn2Sel=11 for ANDI/ORI, 10 otherwise. ALUOp: ADDI 000, ANDI 011, ORI 100, SLTI 101 -> IWB.
  - IWB: RFWE=1, MtoRFSel=00, RFDSel=00 -> FETCH.
  - FAULT: all enables 0. Terminal until RST.
- Opcode is sampled in DECODE and stored in an internal register. All later states decode the stored value, so an IR change cannot alter control flow.
- Watchdog:
  - Clears on entry to any wait state and increments each cycle MemRdy=0 in FETCH, MEMREAD or MEMWRITE.
  - Reaching TIMEOUT with MemRdy=0 moves to FAULT, FaultCode=10, with no write issued.
  - MemRdy=1 on the TIMEOUT cycle completes the access normally; the access wins over the timeout.
- Retired:
  - Increments by 1 on the last cycle of each instruction: MEMWB, MEMWRITE when MemRdy=1, ALUWB, BRANCH, JUMP, JAL, IWB.
  - Wraps modulo 2**CNTW.
- MemRdy outside the wait states is ignored.

Decomposition:
- Shared package mc_pkg holds:
  - opcode localparams;
  - ALUOp encodings;
  - ALUIn2Sel, PCSel, MtoRFSel and RFDSel encodings;
  - state enumeration;
  - FaultCode values.
- One sub-module, mc_wait_timer: watchdog counter with clear, enable and expired outputs.
- Next-state logic, output decode and the Retired counter stay in mc_main_fsm.

Test Plan:
- RST=1 for 2 cycles, then LW with MemRdy tied to 1 -> FETCH, DECODE, MEMADDR, MEMREAD, MEMWB. RFWE=1 only in MEMWB with MtoRFSel=01. Retired=1 after 5 cycles.
- FETCH with MemRdy low for 3 cycles -> MemReq=1 for 4 cycles. IRWE/PCWE pulse exactly once, on the 4th cycle.
- JAL (000011) -> JAL-state cycle shows PCWE=1, RFWE=1, RFDSel=10, MtoRFSel=10, PCSel=10.
- BNE (000101) vs BEQ (000100) -> BranchNE=1/Branch=0 and the converse respectively. ANDI shows ALUIn2Sel=11, ALUOp=011.
- Opcode 111111 in DECODE -> FAULT, FaultCode=01, all enables 0 indefinitely. RST recovers the FSM to FETCH.
- SW with MemRdy never asserted and TIMEOUT=4 -> FAULT with FaultCode=10 after 4 wait cycles. A repeat run with MemRdy=1 on the 4th wait cycle completes normally and Retired increments.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset main controller: opcodes,
// datapath select codes, FSM states, fault codes and the per-state control decode.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] SRC2_REGB = 2'b00;
  localparam logic [1:0] SRC2_FOUR = 2'b01;
  localparam logic [1:0] SRC2_SIMM = 2'b10;
  localparam logic [1:0] SRC2_ZIMM = 2'b11;

  localparam logic [1:0] PC_ALURES = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_LINK   = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC, S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_IEXEC, S_IWB, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_ILLEGAL = 2'b01,
    FC_TIMEOUT = 2'b10
  } fault_e;

  typedef struct packed {
    logic       mem_req;
    logic       mwe;
    logic       pcwe;
    logic       branch;
    logic       branch_ne;
    logic       rfwe;
    logic [2:0] alu_op;
    logic       alu_in1;
    logic [1:0] alu_in2;
    logic [1:0] pc_sel;
    logic [1:0] mtorf;
    logic [1:0] rfd;
    logic       id_sel;
  } ctrl_t;

  function automatic logic is_wait(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

  // Moore control word for a state; op is the stored opcode for the
  // instruction in flight. Anything not named stays 0.
  function automatic ctrl_t decode_ctrl(input state_e s, input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_req = 1'b1;
        c.alu_in2 = SRC2_FOUR;
        c.alu_op  = ALU_ADD;
        c.pc_sel  = PC_ALURES;
      end
      S_DECODE:  c.alu_in2 = SRC2_SIMM;
      S_MEMADDR: begin
        c.alu_in1 = 1'b1;
        c.alu_in2 = SRC2_SIMM;
        c.alu_op  = ALU_ADD;
      end
      S_MEMREAD: begin
        c.mem_req = 1'b1;
        c.id_sel  = 1'b1;
      end
      S_MEMWB: begin
        c.rfwe  = 1'b1;
        c.mtorf = WB_MDR;
        c.rfd   = DST_RT;
      end
      S_MEMWRITE: begin
        c.mem_req = 1'b1;
        c.mwe     = 1'b1;
        c.id_sel  = 1'b1;
      end
      S_EXEC: begin
        c.alu_in1 = 1'b1;
        c.alu_in2 = SRC2_REGB;
        c.alu_op  = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.rfwe  = 1'b1;
        c.mtorf = WB_ALUOUT;
        c.rfd   = DST_RD;
      end
      S_BRANCH: begin
        c.alu_in1   = 1'b1;
        c.alu_in2   = SRC2_REGB;
        c.alu_op    = ALU_SUB;
        c.pc_sel    = PC_ALUOUT;
        c.branch    = (op == OP_BEQ);
        c.branch_ne = (op == OP_BNE);
      end
      S_JUMP: begin
        c.pcwe   = 1'b1;
        c.pc_sel = PC_JUMP;
      end
      S_JAL: begin
        c.pcwe   = 1'b1;
        c.pc_sel = PC_JUMP;
        c.rfwe   = 1'b1;
        c.mtorf  = WB_LINK;
        c.rfd    = DST_RA;
      end
      S_IEXEC: begin
        c.alu_in1 = 1'b1;
        case (op)
          OP_ANDI: begin c.alu_in2 = SRC2_ZIMM; c.alu_op = ALU_AND; end
          OP_ORI:  begin c.alu_in2 = SRC2_ZIMM; c.alu_op = ALU_OR;  end
          OP_SLTI: begin c.alu_in2 = SRC2_SIMM; c.alu_op = ALU_SLT; end
          default: begin c.alu_in2 = SRC2_SIMM; c.alu_op = ALU_ADD; end
        endcase
      end
      S_IWB: begin
        c.rfwe  = 1'b1;
        c.mtorf = WB_ALUOUT;
        c.rfd   = DST_RT;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-wait watchdog: counts stalled cycles in a wait state and flags the
// cycle on which the TIMEOUT-th consecutive wait is being spent.
module mc_wait_timer #(
  parameter int TOW     = 8,
  parameter int TIMEOUT = 200
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TOW-1:0] count_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge CLK) begin
    if (RST || clear_i) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + TOW'(1);
    end
  end

  // The count starts at 0 on the first wait cycle, so TIMEOUT-1 marks the last one.
  assign expired_o = (count_q == TOW'(TIMEOUT - 1));

endmodule

// File: rtl/mc_main_fsm.sv
// Main Moore controller for the multicycle MIPS-subset datapath, with a
// variable-latency memory handshake, watchdog, sticky fault and retire counter.
module mc_main_fsm
  import mc_pkg::*;
#(
  parameter int OPW     = 6,
  parameter int ALUOPW  = 3,
  parameter int TOW     = 8,
  parameter int TIMEOUT = 200,
  parameter int CNTW    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [OPW-1:0]    Opcode,
  input  logic              MemRdy,
  output logic              MemReq,
  output logic              IRWE,
  output logic              MWE,
  output logic              PCWE,
  output logic              Branch,
  output logic              BranchNE,
  output logic              RFWE,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              ALUIn1Sel,
  output logic [1:0]        ALUIn2Sel,
  output logic [1:0]        PCSel,
  output logic [1:0]        MtoRFSel,
  output logic [1:0]        RFDSel,
  output logic              IDSel,
  output logic              Fault,
  output logic [1:0]        FaultCode,
  output logic [CNTW-1:0]   Retired
);

  state_e          state_q, state_d;
  logic [OPW-1:0]  op_q, op_d;
  fault_e          fault_q, fault_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic [CNTW-1:0] retired_q;
  logic            retire;
  logic            tmr_clear, tmr_en, tmr_expired;

  // Any state change clears the watchdog, so it reads 0 on entry to a wait state.
  assign tmr_clear = (state_d != state_q);
  assign tmr_en    = is_wait(state_q) && !MemRdy;

  mc_wait_timer #(
    .TOW     (TOW),
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .CLK       (CLK),
    .RST       (RST),
    .clear_i   (tmr_clear),
    .en_i      (tmr_en),
    .expired_o (tmr_expired)
  );

  // NOTE: every variable gets a default first so no path through the case
  // can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    fault_d = fault_q;
    retire  = 1'b0;
    unique case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        if (MemRdy) begin
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
          fault_d = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        op_d = Opcode;
        case (6'(Opcode))
          OP_LW, OP_SW:                      state_d = S_MEMADDR;
          OP_RTYPE:                          state_d = S_EXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
          default: begin
            state_d = S_FAULT;
            fault_d = FC_ILLEGAL;
          end
        endcase
      end
      S_MEMADDR: state_d = (6'(op_q) == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (MemRdy) begin
          state_d = S_MEMWB;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
          fault_d = FC_TIMEOUT;
        end
      end
      S_MEMWRITE: begin
        if (MemRdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (tmr_expired) begin
          state_d = S_FAULT;
          fault_d = FC_TIMEOUT;
        end
      end
      S_EXEC:  state_d = S_ALUWB;
      S_IEXEC: state_d = S_IWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_JAL, S_IWB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_RESET;
    endcase
    // Outputs are decoded one cycle early so they leave the block registered.
    ctrl_d = decode_ctrl(state_d, 6'(op_d));
  end

  // NOTE: the registered control word is reset along with the state so no
  // enable is live on the cycle after RST, even mid-instruction.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_RESET;
      op_q      <= '0;
      fault_q   <= FC_NONE;
      ctrl_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fault_q <= fault_d;
      ctrl_q  <= ctrl_d;
      if (retire) begin
        retired_q <= retired_q + CNTW'(1);
      end
    end
  end

  // The fetch write pulses follow MemRdy combinationally so IR and PC load
  // exactly on the cycle the fetch completes.
  assign IRWE      = (state_q == S_FETCH) && MemRdy;
  assign PCWE      = ctrl_q.pcwe || IRWE;
  assign MemReq    = ctrl_q.mem_req;
  assign MWE       = ctrl_q.mwe && ctrl_q.mem_req;
  assign Branch    = ctrl_q.branch;
  assign BranchNE  = ctrl_q.branch_ne;
  assign RFWE      = ctrl_q.rfwe;
  assign ALUOp     = ALUOPW'(ctrl_q.alu_op);
  assign ALUIn1Sel = ctrl_q.alu_in1;
  assign ALUIn2Sel = ctrl_q.alu_in2;
  assign PCSel     = ctrl_q.pc_sel;
  assign MtoRFSel  = ctrl_q.mtorf;
  assign RFDSel    = ctrl_q.rfd;
  assign IDSel     = ctrl_q.id_sel;
  assign Fault     = (fault_q != FC_NONE);
  assign FaultCode = fault_q;
  assign Retired   = retired_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Directed, table-driven bench for mc_main_fsm with a short watchdog (TIMEOUT=4).
module tb_mc_main_fsm;

  localparam logic [5:0] T_RTYPE = 6'b000000, T_J    = 6'b000010, T_JAL  = 6'b000011;
  localparam logic [5:0] T_BEQ   = 6'b000100, T_BNE  = 6'b000101, T_ADDI = 6'b001000;
  localparam logic [5:0] T_SLTI  = 6'b001010, T_ANDI = 6'b001100, T_ORI  = 6'b001101;
  localparam logic [5:0] T_LW    = 6'b100011, T_SW   = 6'b101011, T_BAD  = 6'b111111;

  typedef struct packed {
    logic       mem_req;
    logic       irwe;
    logic       mwe;
    logic       pcwe;
    logic       branch;
    logic       branch_ne;
    logic       rfwe;
    logic [2:0] alu_op;
    logic       alu_in1;
    logic [1:0] alu_in2;
    logic [1:0] pc_sel;
    logic [1:0] mtorf;
    logic [1:0] rfd;
    logic       id_sel;
  } ctrl_exp_t;

  typedef struct {
    logic       rst;
    logic [5:0] op;
    logic       rdy;
    ctrl_exp_t  exp;
    logic [1:0] code;
    int         ret;
  } vec_t;

  localparam ctrl_exp_t E_IDLE     = '0;
  localparam ctrl_exp_t E_FETCH_W  = '{mem_req:1'b1, alu_in2:2'b01, default:'0};
  localparam ctrl_exp_t E_FETCH_R  = '{mem_req:1'b1, irwe:1'b1, pcwe:1'b1, alu_in2:2'b01, default:'0};
  localparam ctrl_exp_t E_DECODE   = '{alu_in2:2'b10, default:'0};
  localparam ctrl_exp_t E_MEMADDR  = '{alu_in1:1'b1, alu_in2:2'b10, default:'0};
  localparam ctrl_exp_t E_MEMREAD  = '{mem_req:1'b1, id_sel:1'b1, default:'0};
  localparam ctrl_exp_t E_MEMWB    = '{rfwe:1'b1, mtorf:2'b01, default:'0};
  localparam ctrl_exp_t E_MEMWRITE = '{mem_req:1'b1, mwe:1'b1, id_sel:1'b1, default:'0};
  localparam ctrl_exp_t E_EXEC     = '{alu_in1:1'b1, alu_op:3'b010, default:'0};
  localparam ctrl_exp_t E_ALUWB    = '{rfwe:1'b1, rfd:2'b01, default:'0};
  localparam ctrl_exp_t E_BEQ      = '{alu_in1:1'b1, alu_op:3'b001, pc_sel:2'b01, branch:1'b1, default:'0};
  localparam ctrl_exp_t E_BNE      = '{alu_in1:1'b1, alu_op:3'b001, pc_sel:2'b01, branch_ne:1'b1, default:'0};
  localparam ctrl_exp_t E_JUMP     = '{pcwe:1'b1, pc_sel:2'b10, default:'0};
  localparam ctrl_exp_t E_JAL      = '{pcwe:1'b1, pc_sel:2'b10, rfwe:1'b1, mtorf:2'b10, rfd:2'b10, default:'0};
  localparam ctrl_exp_t E_ADDI     = '{alu_in1:1'b1, alu_in2:2'b10, alu_op:3'b000, default:'0};
  localparam ctrl_exp_t E_ANDI     = '{alu_in1:1'b1, alu_in2:2'b11, alu_op:3'b011, default:'0};
  localparam ctrl_exp_t E_ORI      = '{alu_in1:1'b1, alu_in2:2'b11, alu_op:3'b100, default:'0};
  localparam ctrl_exp_t E_SLTI     = '{alu_in1:1'b1, alu_in2:2'b10, alu_op:3'b101, default:'0};
  localparam ctrl_exp_t E_IWB      = '{rfwe:1'b1, default:'0};

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [5:0]  Opcode = '0;
  logic        MemRdy = 1'b1;
  logic        MemReq, IRWE, MWE, PCWE, Branch, BranchNE, RFWE, ALUIn1Sel, IDSel, Fault;
  logic [2:0]  ALUOp;
  logic [1:0]  ALUIn2Sel, PCSel, MtoRFSel, RFDSel, FaultCode;
  logic [31:0] Retired;
  ctrl_exp_t   act;

  int n_total = 0;
  int n_pass  = 0;
  vec_t vecs[$];

  always #5 CLK = ~CLK;

  mc_main_fsm #(
    .OPW(6), .ALUOPW(3), .TOW(8), .TIMEOUT(4), .CNTW(32)
  ) dut (
    .CLK(CLK), .RST(RST), .Opcode(Opcode), .MemRdy(MemRdy),
    .MemReq(MemReq), .IRWE(IRWE), .MWE(MWE), .PCWE(PCWE),
    .Branch(Branch), .BranchNE(BranchNE), .RFWE(RFWE), .ALUOp(ALUOp),
    .ALUIn1Sel(ALUIn1Sel), .ALUIn2Sel(ALUIn2Sel), .PCSel(PCSel),
    .MtoRFSel(MtoRFSel), .RFDSel(RFDSel), .IDSel(IDSel),
    .Fault(Fault), .FaultCode(FaultCode), .Retired(Retired)
  );

  assign act = {MemReq, IRWE, MWE, PCWE, Branch, BranchNE, RFWE, ALUOp,
                ALUIn1Sel, ALUIn2Sel, PCSel, MtoRFSel, RFDSel, IDSel};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, want);
  endtask

  task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                     input ctrl_exp_t e, input logic [1:0] code, input int ret);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.exp = e; v.code = code; v.ret = ret;
    vecs.push_back(v);
  endtask

  task automatic add_n(input int n, input logic [5:0] op, input logic rdy,
                       input ctrl_exp_t e, input logic [1:0] code, input int ret);
    for (int k = 0; k < n; k++) add(1'b0, op, rdy, e, code, ret);
  endtask

  initial begin
    int waits;
    int pulses;

    // Reset, then LW with memory always ready.
    add(1, T_RTYPE, 1, E_IDLE,    0, 0);
    add(0, T_RTYPE, 1, E_IDLE,    0, 0);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 0);
    add(0, T_LW,    1, E_DECODE,  0, 0);
    add(0, T_BAD,   1, E_MEMADDR, 0, 0);
    add(0, T_BAD,   1, E_MEMREAD, 0, 0);
    add(0, T_BAD,   1, E_MEMWB,   0, 0);
    // Fetch stalls three cycles; completes on the last allowed wait cycle.
    add_n(3, T_RTYPE, 0, E_FETCH_W, 0, 1);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 1);
    add(0, T_JAL,   1, E_DECODE,  0, 1);
    add(0, T_BAD,   1, E_JAL,     0, 1);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 2);
    add(0, T_BNE,   0, E_DECODE,  0, 2);
    add(0, T_BEQ,   0, E_BNE,     0, 2);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 3);
    add(0, T_BEQ,   0, E_DECODE,  0, 3);
    add(0, T_BNE,   0, E_BEQ,     0, 3);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 4);
    add(0, T_ANDI,  0, E_DECODE,  0, 4);
    add(0, T_BAD,   0, E_ANDI,    0, 4);
    add(0, T_RTYPE, 0, E_IWB,     0, 4);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 5);
    add(0, T_RTYPE, 0, E_DECODE,  0, 5);
    add(0, T_RTYPE, 0, E_EXEC,    0, 5);
    add(0, T_RTYPE, 0, E_ALUWB,   0, 5);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 6);
    add(0, T_J,     0, E_DECODE,  0, 6);
    add(0, T_RTYPE, 0, E_JUMP,    0, 6);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 7);
    // SW completing on the 4th wait cycle, then SW that times out.
    add(0, T_SW,    0, E_DECODE,   0, 7);
    add(0, T_BAD,   0, E_MEMADDR,  0, 7);
    add_n(3, T_RTYPE, 0, E_MEMWRITE, 0, 7);
    add(0, T_RTYPE, 1, E_MEMWRITE, 0, 7);
    add(0, T_RTYPE, 1, E_FETCH_R,  0, 8);
    add(0, T_SW,    0, E_DECODE,   0, 8);
    add(0, T_RTYPE, 0, E_MEMADDR,  0, 8);
    add_n(4, T_RTYPE, 0, E_MEMWRITE, 0, 8);
    add_n(2, T_RTYPE, 1, E_IDLE,     2, 8);
    add(1, T_RTYPE, 1, E_IDLE,    2, 8);
    add(0, T_RTYPE, 1, E_IDLE,    0, 0);
    // Illegal opcode, sticky until reset.
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 0);
    add(0, T_BAD,   1, E_DECODE,  0, 0);
    add_n(3, T_LW,  1, E_IDLE,    1, 0);
    add(1, T_RTYPE, 1, E_IDLE,    1, 0);
    add(0, T_RTYPE, 1, E_IDLE,    0, 0);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 0);
    add(0, T_ORI,   0, E_DECODE,  0, 0);
    add(0, T_RTYPE, 0, E_ORI,     0, 0);
    add(0, T_RTYPE, 0, E_IWB,     0, 0);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 1);
    add(0, T_SLTI,  0, E_DECODE,  0, 1);
    add(0, T_RTYPE, 0, E_SLTI,    0, 1);
    add(0, T_RTYPE, 0, E_IWB,     0, 1);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 2);
    // Reset during IEXEC must suppress the following write-back.
    add(0, T_ADDI,  0, E_DECODE,  0, 2);
    add(1, T_RTYPE, 0, E_ADDI,    0, 2);
    add(0, T_RTYPE, 1, E_IDLE,    0, 0);
    add(0, T_RTYPE, 1, E_FETCH_R, 0, 0);
    // LW whose read never completes.
    add(0, T_LW,    0, E_DECODE,  0, 0);
    add(0, T_RTYPE, 0, E_MEMADDR, 0, 0);
    add_n(4, T_RTYPE, 0, E_MEMREAD, 0, 0);
    add(0, T_RTYPE, 0, E_IDLE,    2, 0);

    foreach (vecs[i]) begin
      @(negedge CLK);
      RST    = vecs[i].rst;
      Opcode = vecs[i].op;
      MemRdy = vecs[i].rdy;
      #1;
      check($sformatf("ctrl[%0d]", i), 32'(act), 32'(vecs[i].exp));
      check($sformatf("fault[%0d]", i), {29'd0, Fault, FaultCode},
            {29'd0, (vecs[i].code != 2'b00), vecs[i].code});
      check($sformatf("retired[%0d]", i), Retired, 32'(vecs[i].ret));
    end

    // Fetch timeout counted cycle by cycle, bounded in case Fault never rises.
    @(negedge CLK); RST = 1'b1; MemRdy = 1'b0; Opcode = T_RTYPE;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
    waits = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (Fault) break;
      if (MemReq) waits++;
      if (IRWE || PCWE) pulses++;
      @(negedge CLK);
    end
    check("wd_wait_cycles", 32'(waits), 32'd4);
    check("wd_fault", {29'd0, Fault, FaultCode}, 32'b110);
    check("wd_no_write", 32'(pulses), 32'd0);
    check("wd_fault_enables", 32'(act), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
